// File: rtl/rvmyth_avsdadc_sar_if.sv
// Result handshake between the SAR ADC controller and the RVMyth core.
// The master side presents a finished conversion; the slave side accepts it with ready.
interface rvmyth_avsdadc_sar_if #(
  parameter int unsigned WIDTH = 10
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/rvmyth_avsdadc_sar.sv
// Successive-approximation ADC controller: drives trial codes into the feedback DAC,
// resolves one bit per settle period from the comparator and hands the sample to the core.
module rvmyth_avsdadc_sar #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 cmp_i,
  output logic [WIDTH-1:0]     dac_code_o,
  output logic                 sample_en_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  rvmyth_avsdadc_sar_if.master bus
);

  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               done_c;

  logic [WIDTH-1:0]   dac_code_q, dac_code_d;
  logic               sample_en_q, sample_en_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  // State, counters and partial result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      res_q   <= res_d;
    end
  end

  // Next state: res holds resolved bits above the current index, zeros at and below it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    res_d   = res_q;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SAMPLE;
          cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
          res_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = CONVERT;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          bit_d   = BIT_W'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CONVERT: begin
        if (cnt_q == '0) begin
          res_d[bit_q] = cmp_i;
          if (bit_q == '0) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            bit_d = bit_q - BIT_W'(1);
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the upcoming state so they register in step with it
  always_comb begin
    dac_code_d  = '0;
    sample_en_d = 1'b0;
    busy_d      = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    unique case (state_d)
      SAMPLE: begin
        sample_en_d = 1'b1;
        busy_d      = 1'b1;
      end
      CONVERT: begin
        busy_d     = 1'b1;
        dac_code_d = res_d | (WIDTH'(1) << bit_d);
      end
      default: begin
      end
    endcase
    // A completion wins over a same-edge accept and is then not an overrun
    if (done_c) begin
      data_d  = res_d;
      valid_d = 1'b1;
      if (valid_q && !bus.ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dac_code_q  <= '0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dac_code_q  <= dac_code_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dac_code_o  = dac_code_q;
  assign sample_en_o = sample_en_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;
  assign bus.data    = data_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_rvmyth_avsdadc_sar.sv
// Bench for rvmyth_avsdadc_sar: ideal comparator, cycle-phase reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_rvmyth_avsdadc_sar;

  localparam int unsigned W     = 10;
  localparam int unsigned S     = 4;
  localparam int unsigned T     = 2;
  localparam int unsigned TOTAL = S + W * T;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b1;
  logic [W-1:0] vin   = '0;
  logic         cmp;
  logic [W-1:0] dac_code;
  logic         sample_en;
  logic         busy;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;

  rvmyth_avsdadc_sar_if #(.WIDTH(W)) bus ();
  assign bus.ready = ready;

  // Ideal comparator against the DAC trial code
  assign cmp = (vin >= dac_code);

  rvmyth_avsdadc_sar #(
    .WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start), .cmp_i(cmp),
    .dac_code_o(dac_code), .sample_en_o(sample_en), .busy_o(busy),
    .overrun_o(overrun), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: phase = cycles since the accepting edge (0 = idle)
  int unsigned  m_phase = 0;
  logic [W-1:0] m_trial [W];
  logic [W-1:0] m_res   = '0;
  logic [W-1:0] m_data  = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;

  always @(posedge clk) begin : model
    logic [W-1:0] code;
    logic [W-1:0] t;
    if (reset) begin
      m_phase = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_ovr   = 1'b0;
    end else if (m_phase == TOTAL) begin
      if (m_valid && !ready) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = m_res;
      m_phase = 0;
    end else begin
      if (m_valid && ready) m_valid = 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1;
          code = '0;
          for (int k = 0; k < W; k++) begin
            t = code | (W'(1) << (W - 1 - k));
            m_trial[k] = t;
            if (vin >= t) code = t;
          end
          m_res = code;
        end
      end else begin
        m_phase++;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [W-1:0] e_dac;
    e_dac = '0;
    if (m_phase > S) e_dac = m_trial[(m_phase - S - 1) / T];
    check("m_dac_code",  32'(dac_code),  32'(e_dac));
    check("m_sample_en", 32'(sample_en), 32'(m_phase >= 1 && m_phase <= S));
    check("m_busy",      32'(busy),      32'(m_phase != 0));
    check("m_data",      32'(bus.data),  32'(m_data));
    check("m_valid",     32'(bus.valid), 32'(m_valid));
    check("m_overrun",   32'(overrun),   32'(m_ovr));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start one conversion and return on the cycle after it completes
  task automatic convert(input logic [W-1:0] v);
    int i = 0;
    vin   = v;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    while (busy && i < 40) begin
      cyc(1);
      i++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL convert_timeout: busy still 1 after 40 cycles, expected 0");
    end
  endtask

  task automatic test_basic();
    ready = 1'b1;
    vin   = 10'h2AB;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_sample_en", 32'(sample_en), 32'd1);
    cyc(4);  check("trial0", 32'(dac_code), 32'h200);
    cyc(2);  check("trial1", 32'(dac_code), 32'h300);
    cyc(2);  check("trial2", 32'(dac_code), 32'h280);
    cyc(2);  check("trial3", 32'(dac_code), 32'h2C0);
    cyc(13);
    check("c24_busy", 32'(busy), 32'd1);
    check("c24_valid", 32'(bus.valid), 32'd0);
    cyc(1);
    check("c25_busy", 32'(busy), 32'd0);
    check("c25_valid", 32'(bus.valid), 32'd1);
    check("c25_data", 32'(bus.data), 32'h2AB);
    cyc(1);
    check("c26_valid", 32'(bus.valid), 32'd0);
  endtask

  task automatic test_endpoints();
    convert(10'h3FF); check("ep_3ff", 32'(bus.data), 32'h3FF);
    convert(10'h000); check("ep_000", 32'(bus.data), 32'h000);
    convert(10'h200); check("ep_200", 32'(bus.data), 32'h200);
    cyc(2);
  endtask

  task automatic test_held_start();
    int n = 0;
    int nv = 0;
    int t1 = 0;
    int t2 = 0;
    int se1 = 0;
    int se2 = 0;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    ready = 1'b1;
    vin   = 10'h155;
    start = 1'b1;
    while (nv < 2 && n < 80) begin
      cyc(1);
      n++;
      if (sample_en) begin
        if (nv == 0) se1++;
        else se2++;
      end
      if (bus.valid) begin
        if (nv == 0) begin
          d1 = bus.data; t1 = n; vin = 10'h0AA;
        end else begin
          d2 = bus.data; t2 = n; start = 1'b0;
        end
        nv++;
      end
    end
    start = 1'b0;
    check("held_results", 32'(nv), 32'd2);
    check("held_d1", 32'(d1), 32'h155);
    check("held_d2", 32'(d2), 32'h0AA);
    check("held_t1", 32'(t1), 32'd25);
    check("held_spacing", 32'(t2 - t1), 32'd25);
    check("held_se1", 32'(se1), 32'd4);
    check("held_se2", 32'(se2), 32'd4);
    cyc(2);
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    convert(10'h123);
    convert(10'h321);
    check("ovr_data", 32'(bus.data), 32'h321);
    check("ovr_valid", 32'(bus.valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    ready = 1'b1;
    cyc(1);
    check("ovr_accept_valid", 32'(bus.valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("ovr_reset", 32'(overrun), 32'd0);
  endtask

  task automatic test_accept_on_done();
    ready = 1'b0;
    convert(10'h111);
    vin   = 10'h2EE;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(23);
    ready = 1'b1;
    cyc(1);
    check("aod_valid", 32'(bus.valid), 32'd1);
    check("aod_data", 32'(bus.data), 32'h2EE);
    check("aod_overrun", 32'(overrun), 32'd0);
    cyc(1);
    check("aod_cleared", 32'(bus.valid), 32'd0);
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    vin   = 10'h3A5;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(13);
    check("rm_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    cyc(1);
    check("rm_dac", 32'(dac_code), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_sample_en", 32'(sample_en), 32'd0);
    check("rm_valid", 32'(bus.valid), 32'd0);
    check("rm_data", 32'(bus.data), 32'd0);
    reset = 1'b0;
    cyc(2);
    convert(10'h0F0);
    check("rm_reconvert", 32'(bus.data), 32'h0F0);
    cyc(2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      cyc(1);
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      ready = 1'($urandom_range(0, 1));
      if (m_phase == 0) vin = W'($urandom);
    end
    reset = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    cyc(30);
  endtask

  initial begin
    cyc(2);
    check("rst_dac", 32'(dac_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    cyc(1);
    test_basic();
    test_endpoints();
    test_held_start();
    test_overrun();
    test_accept_on_done();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
